// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with a sign-fix cycle and architectural Hi/Lo registers.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [1:0]       dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               is_div_q, is_div_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               sa, sb, qbit;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = 1'b0;
        sa       = Op[0] & A[WIDTH-1];
        sb       = Op[0] & B[WIDTH-1];
        a_mag    = sa ? -A : A;
        b_mag    = sb ? -B : B;
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
        shifted  = {rem_q, acc_q[WIDTH-1]};
        // Bit WIDTH of the difference is the borrow: set means the divisor did not fit.
        diff     = shifted - {1'b0, mcand_q};
        qbit     = ~diff[WIDTH];
        prod     = neg_q ? -acc_q : acc_q;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (Op[1] && (B == '0)) begin
                        state_d = S_DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(WIDTH);
                        is_div_d = Op[1];
                        neg_d    = sa ^ sb;
                        rneg_d   = sa;
                        rem_d    = '0;
                        if (Op[1]) begin
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            mcand_d = b_mag;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            mcand_d = a_mag;
                        end
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    rem_d = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};
                end else begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (is_div_q) begin
                    lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rneg_q ? -rem_q : rem_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivZero   = dz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign dbg_state = state_q;
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit for the multicycle MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU over WIDTH cycles using a start/busy/done handshake.
- Holds the architectural Hi/Lo results, which the datapath reads through its write-back mux.
- The control FSM stalls on Busy and resumes on Done.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 4.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  input  WIDTH  multiplicand / dividend; sampled with Start.
- B  input  WIDTH  multiplier / divisor; sampled with Start.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle completion pulse.
- DivZero  output  1  one-cycle flag, coincident with Done, for a divide with B==0.
- Hi  output  WIDTH  product high half / remainder.
- Lo  output  WIDTH  product low half / quotient.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. Busy=0, Done=0, DivZero=0, Hi=0, Lo=0. Internal counter and working registers are cleared. An operation in flight is aborted and leaves no partial result.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE -> RUN on a clock edge with Start=1, except a divide with B==0, which goes IDLE -> DONE. At that edge, A, B and Op are captured. For signed ops (MULT, DIV), operands are converted to magnitudes and the sign of each operand is recorded. The step counter is loaded with WIDTH.
- RUN, multiply: shift-add, one multiplier bit per cycle, with a 2*WIDTH unsigned accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, with a WIDTH+1 bit partial remainder.
- RUN -> FIX when the counter reaches 0, after exactly WIDTH cycles in RUN.
- FIX (1 cycle) applies sign correction:
  - Product is negated (two's complement over 2*WIDTH bits) if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Unsigned ops pass through unchanged.
- FIX -> DONE. Hi/Lo load on the edge entering DONE:
  - Multiply: {Hi,Lo} = 2*WIDTH-bit product.
  - Divide: Lo = quotient, Hi = remainder.
- DONE (1 cycle): Done=1, then the FSM returns to IDLE unconditionally. Start is ignored in DONE.
- Busy = 1 in RUN and FIX; 0 in IDLE and DONE.
- Latency: Done is high in the cycle that begins WIDTH+2 edges after the Start-sampling edge. With WIDTH=32, that is 34 edges.
- Divide by zero: IDLE -> DONE directly. Done=1 and DivZero=1 in the following cycle, and Hi/Lo keep their previous values.
- Signed overflow (DIV of the most-negative value by -1): Lo = most-negative value, Hi = 0. No flag is raised.
- Start is ignored in every state other than IDLE; the inputs A, B and Op are not re-sampled.
- Hi/Lo hold their values in all states except the DONE-entry load. They remain readable while the next operation runs.
- Done and DivZero are registered outputs; they never glitch combinationally.

Test Plan:
- WIDTH=32, MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Done pulses exactly 34 edges after Start; Busy is high for 33 cycles.
- MULT A=-3 (0xFFFFFFFD), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- DIVU A=100, B=7 -> Lo=14, Hi=2. DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU A=5, B=0 with previous Hi=2, Lo=14 -> Done=1 and DivZero=1 one cycle after Start; Hi=2, Lo=14 unchanged; Busy never asserted.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0, DivZero=0.
- Start re-pulsed with new operands during RUN -> ignored; the result matches the first operands. Reset asserted mid-RUN (asynchronous, between edges) -> Busy=0, Hi=Lo=0 immediately, no Done pulse; the next Start (MULTU 6*7) yields Lo=42, Hi=0.
